// File: rtl/ped_tick_conditioner.sv
// Pedestrian button conditioner and one-second roll tick for the traffic-light sequencer.
// Optional request lockout after an accepted press is enabled by defining PED_LOCKOUT_EN.
module ped_tick_conditioner #(
    parameter int TICK_DIV        = 10000000,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int LOCKOUT_TICKS   = 23
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic roll,
    output logic btn,
    output logic btn_level,
    output logic lockout_active
);

    // state        | meaning
    // IDLE         | debounced level low, waiting for btn_s high
    // PRESS_WAIT   | btn_s high, counting stable cycles before accepting press
    // HELD         | debounced level high, waiting for btn_s low
    // RELEASE_WAIT | btn_s low, counting stable cycles before accepting release

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    logic            sync_meta;
    logic            btn_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick_last;
    db_state_t       state;
    db_state_t       state_nxt;
    logic [DW-1:0]   db_cnt;
    logic [DW-1:0]   db_cnt_nxt;
    logic            level_nxt;
    logic            accept;
    logic            accept_ok;
    logic            pending;
    logic            fire_req;
    logic            fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            btn_s     <= sync_meta;
        end
    end

    assign tick_last = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            roll     <= 1'b0;
        end else begin
            tick_cnt <= tick_last ? '0 : tick_cnt + TW'(1);
            roll     <= tick_last;
        end
    end

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        level_nxt  = btn_level;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = HELD;
                    level_nxt = 1'b1;
                    accept    = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                // a bounce back high returns to HELD silently: no second press event
                if (btn_s) begin
                    state_nxt = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
                level_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            btn_level <= level_nxt;
        end
    end

`ifdef PED_LOCKOUT_EN
    localparam int LW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_TICKS);

    logic [LW-1:0] lock_cnt;

    assign lockout_active = (lock_cnt != '0);
    assign accept_ok      = accept && !lockout_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
        end else if (fire) begin
            lock_cnt <= LOCK_LOAD;
        end else if (roll && (lock_cnt != '0)) begin
            lock_cnt <= lock_cnt - LW'(1);
        end
    end
`else
    logic lock_unused;

    assign lock_unused    = (LOCKOUT_TICKS != 0);
    assign lockout_active = 1'b0;
    assign accept_ok      = accept;
`endif

    // roll wins a collision; the press is deferred one cycle (TICK_DIV >= 2 keeps it clear of the next roll)
    assign fire_req = accept_ok || pending;
    assign fire     = fire_req && !tick_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn     <= 1'b0;
            pending <= 1'b0;
        end else begin
            btn     <= fire;
            pending <= fire_req && tick_last;
        end
    end

endmodule

// File: tb/tb_ped_tick_conditioner.sv
// Randomised and directed bench for ped_tick_conditioner with a cycle-level reference model.
// Lockout expectations follow PED_LOCKOUT_EN when the bench is built with it.
module tb_ped_tick_conditioner;

    localparam int T = 8;
    localparam int D = 4;
    localparam int L = 3;
`ifdef PED_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic btn_raw;
    logic roll;
    logic btn;
    logic btn_level;
    logic lockout_active;

    ped_tick_conditioner #(
        .TICK_DIV(T),
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_TICKS(L)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .roll(roll),
        .btn(btn),
        .btn_level(btn_level),
        .lockout_active(lockout_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: edges since reset, raw sample history, debounced window, pending, lockout
    int cyc;
    bit rawq[$];
    bit winq[$];
    bit m_level;
    bit m_pend;
    bit m_roll_prev;
    int m_lock;
    int btn_seen;
    int last_btn_cyc;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        cyc = 0;
        rawq.delete();
        winq.delete();
        m_level = 1'b0;
        m_pend = 1'b0;
        m_roll_prev = 1'b0;
        m_lock = 0;
    endtask

    // called at a negedge; drives raw, advances one edge, checks at the following negedge
    task automatic tick(input bit r);
        bit s, same, accept, want, exp_roll, exp_btn, lock_before;
        btn_raw = r;
        @(posedge clk);
        cyc++;
        rawq.push_back(r);
        s = (rawq.size() > 2) ? rawq.pop_front() : 1'b0;
        winq.push_back(s);
        if (winq.size() > D + 1) void'(winq.pop_front());
        accept = 1'b0;
        if (winq.size() == D + 1) begin
            same = 1'b1;
            foreach (winq[i]) if (winq[i] == m_level) same = 1'b0;
            if (same) begin
                m_level = !m_level;
                accept = m_level;
            end
        end
        exp_roll = (cyc % T == 0);
        lock_before = (m_lock != 0);
        want = (accept && !lock_before) || m_pend;
        exp_btn = want && !exp_roll;
        m_pend = want && exp_roll;
        if (exp_btn && LOCK_EN) m_lock = L;
        else if (m_roll_prev && m_lock > 0) m_lock--;
        m_roll_prev = exp_roll;
        @(negedge clk);
        chk("roll", roll, exp_roll);
        chk("btn", btn, exp_btn);
        chk("btn_level", btn_level, m_level);
        chk("lockout_active", lockout_active, m_lock != 0);
        if (roll && btn) chk("roll_btn_exclusive", 1'b1, 1'b0);
        if (btn) begin
            btn_seen++;
            last_btn_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_roll", roll, 1'b0);
        chk("rst_btn", btn, 1'b0);
        chk("rst_level", btn_level, 1'b0);
        chk("rst_lockout", lockout_active, 1'b0);
        btn_raw = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_hold_roll", roll, 1'b0);
        chk("rst_hold_btn", btn, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic align_press();
        while ((cyc + 7) % T != 0) tick(1'b0);
    endtask

    initial begin
        int base;
        btn_raw = 1'b0;
        reset_n = 1'b1;
        model_clear();
        btn_seen = 0;
        last_btn_cyc = 0;
        @(negedge clk);
        do_reset();

        // idle: roll on 8, 16, 24
        repeat (26) tick(1'b0);
        chk_int("idle_btn_count", btn_seen, 0);

        // clean press held 20, release
        repeat (2) tick(1'b0);
        base = btn_seen;
        repeat (20) tick(1'b1);
        repeat (15) tick(1'b0);
        chk_int("clean_press_count", btn_seen - base, 1);

        // bounce then hold with a 2-cycle dropout
        repeat (30) tick(1'b0);
        base = btn_seen;
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
        repeat (15) tick(1'b1);
        repeat (2) tick(1'b0);
        repeat (10) tick(1'b1);
        repeat (12) tick(1'b0);
        chk_int("bounce_press_count", btn_seen - base, 1);

        // accept event lands on a roll cycle
        repeat (30) tick(1'b0);
        align_press();
        repeat (7) tick(1'b1);
        chk("collide_roll", roll, 1'b1);
        chk("collide_btn_held_off", btn, 1'b0);
        tick(1'b1);
        chk("collide_btn_next", btn, 1'b1);
        chk_int("collide_btn_phase", last_btn_cyc % T, 1);
        repeat (12) tick(1'b1);
        repeat (12) tick(1'b0);

        // lockout: press, second press within lockout, third after it expires
        repeat (30) tick(1'b0);
        base = btn_seen;
        repeat (8) tick(1'b1);
        repeat (6) tick(1'b0);
        repeat (8) tick(1'b1);
        chk("lockout_mid", lockout_active, LOCK_EN);
        repeat (6) tick(1'b0);
        repeat (30) tick(1'b0);
        chk("lockout_expired", lockout_active, 1'b0);
        repeat (8) tick(1'b1);
        repeat (8) tick(1'b0);
        chk_int("lockout_press_count", btn_seen - base, LOCK_EN ? 2 : 3);

        // random raw activity
        for (int k = 0; k < 40; k++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            repeat (len) tick(v);
        end
        repeat (40) tick(1'b0);

        // reset during PRESS_WAIT
        repeat (4) tick(1'b1);
        do_reset();
        base = btn_seen;
        repeat (20) tick(1'b0);
        chk_int("rst_press_wait_no_stale", btn_seen - base, 0);

        // reset with a pending pulse
        repeat (30) tick(1'b0);
        align_press();
        repeat (7) tick(1'b1);
        chk("pend_roll_before_rst", roll, 1'b1);
        do_reset();
        base = btn_seen;
        repeat (7) tick(1'b0);
        chk("restart_no_roll_cyc7", roll, 1'b0);
        tick(1'b0);
        chk("restart_roll_cyc8", roll, 1'b1);
        repeat (12) tick(1'b0);
        chk_int("rst_pending_no_stale", btn_seen - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ped_tick_conditioner.md
Name: ped_tick_conditioner

Overview:
- Upstream front-end for the traffic-light sequencer.
- Turns the raw pedestrian push-button into a clean one-cycle request pulse (btn).
- Derives the one-second advance tick (roll) from the system clock.
- Both outputs are single-cycle, clk-synchronous pulses, so the sequencer sees exactly one edge per event.

Parameters:
- TICK_DIV, 10000000, clk cycles per roll period (1 s at 10 MHz); must be >= 2.
- DEBOUNCE_CYCLES, 200000, consecutive stable synchronised cycles needed to accept a level change; must be >= 2.
- LOCKOUT_TICKS, 23, roll ticks after an accepted request during which new requests are dropped (one full light cycle).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw asynchronous push-button, active high, bouncy.
- roll  output  1  one-cycle pulse, once every TICK_DIV cycles.
- btn  output  1  one-cycle pulse per accepted debounced press.
- btn_level  output  1  debounced button level.
- lockout_active  output  1  high while new requests are suppressed.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; sync flops 0; prescaler 0; debounce state IDLE; debounce counter 0; pending flag 0; lockout counter 0.
- Synchroniser: two flops on btn_raw, giving btn_s. The FSM uses only btn_s.
- Prescaler: free-running counter 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - roll is registered, high for the cycle after the counter equals TICK_DIV-1; the counter wraps to 0.
  - First roll occurs TICK_DIV cycles after reset release; period is exactly TICK_DIV.
  - Never paused or reloaded by button activity.
- Debounce FSM, counter width $clog2(DEBOUNCE_CYCLES):
  - IDLE (btn_level=0): btn_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn_s=0 -> IDLE. Otherwise count; at DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, raise accept event.
  - HELD (btn_level=1): btn_s=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn_s=1 -> HELD, with no new accept event. Otherwise count; at DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0.
- Press latency: a clean raw rising edge produces btn high 2 + DEBOUNCE_CYCLES + 1 cycles later.
- Holding the button produces exactly one btn pulse. A release glitch shorter than DEBOUNCE_CYCLES produces no second pulse.
- Collision rule: roll has priority.
  - If an accept event would pulse btn in the same cycle roll is high, set pending and emit btn in the next cycle instead.
  - btn and roll are never high in the same cycle.
- Reset mid-operation: everything returns to the reset state immediately. A press in progress is discarded; a pending pulse is discarded.

Optional Feature:
- Macro: PED_LOCKOUT_EN.
- With PED_LOCKOUT_EN defined:
  - An emitted btn pulse loads the lockout counter with LOCKOUT_TICKS, width $clog2(LOCKOUT_TICKS+1).
  - Each roll pulse decrements the counter, saturating at 0.
  - lockout_active = (counter != 0).
  - Accept events while lockout_active=1 are dropped: no btn, no pending. btn_level still tracks.
  - A load coinciding with a roll decrement takes the load. Given the collision rule, a load never coincides with roll.
- Without the macro: lockout_active tied 0, every accept event yields btn, and LOCKOUT_TICKS is ignored.

Test Plan (TICK_DIV=8, DEBOUNCE_CYCLES=4, LOCKOUT_TICKS=3):
- Reset release, btn_raw=0 -> roll high on cycles 8, 16, 24 (one cycle each); btn=0, btn_level=0, lockout_active=0 throughout.
- btn_raw 0->1 held 20 cycles -> btn single pulse 7 cycles after the edge; btn_level=1; release -> btn_level=0 7 cycles later; no further btn.
- btn_raw bounces 1,0,1,0 at 1-cycle intervals, then steady 1 -> one btn pulse only, timed from the last rising edge; a 2-cycle mid-hold dropout -> no second pulse.
- Press timed so the accept event lands on a roll cycle -> roll on cycle N, btn on N+1, never both high together.
- PED_LOCKOUT_EN: press accepted; second press accepted after 1 roll -> no btn, lockout_active=1; after 3 rolls lockout_active=0; third press -> btn.
- Assert reset_n=0 during PRESS_WAIT and with pending set -> all outputs 0 asynchronously; after release no stale btn, and roll restarts at cycle 8.
